acc_unit: RTL and testbench
===========================

// Module: acc_unit
// PURPOSE
// - Responder end of the acc_req/acc_data dispatch handshake: accepts one FPR operand per handshake and adds it into a running FP32 accumulator.
// - Sits behind the accumulator reservation entry. Exposes the accumulated value, its gc stamp and an element count to a read port.
// - Supports a clear operation; serialises accumulations because each add depends on the previous sum.
// PARAMETERS
// - FADD_LAT  2   cycles from fadd operand launch to valid sum; legal range >=1
// - CNT_WIDTH 16  width of the accumulated-element counter
// PORTS
// - clk         in   1         clock
// - reset       in   1         reset, synchronous, active-high
// - acc_req     req_if        responder side: .valid in, .ready out
// - acc_data    in   32        FP32 operand, qualified by acc_req.valid
// - gc_stamp    in   GC_WIDTH  gc stamp of the operand, qualified by acc_req.valid
// - clear       in   1         pulse: zero accumulator and counter
// - rd_req      req_if        read port: .valid in, .ready out
// - rd_data     out  32        accumulator value, valid on rd_req handshake
// - rd_gc       out  GC_WIDTH  gc stamp of the last accumulated operand
// - rd_count    out  CNT_WIDTH number of operands accumulated since reset/clear
// - busy        out  1         add in flight
// BEHAVIOUR
// - Reset: state=IDLE, acc=32'h0, rd_gc=0, rd_count=0, busy=0, acc_req.ready=0 during reset, rd_req.ready=0 during reset, no pending clear.
// - FSM IDLE -> ADD on accept (acc_req.valid && acc_req.ready). Load lat_cnt=FADD_LAT-1.
// - FSM ADD: decrement lat_cnt; at lat_cnt==0 write the sum to acc and return to IDLE.
// - Accumulation latency: a value accepted at cycle t becomes visible on rd_data at t+FADD_LAT+1.
// - acc_req.ready = (state==IDLE) && !clear && !reset. Max throughput is one operand per FADD_LAT+1 cycles.
// - On accept: fadd inputs latched as (acc, acc_data). rd_gc <= gc_stamp. rd_count <= rd_count+1, saturating at all-ones.
// - rd_req.ready = (state==IDLE) && !reset. rd_data/rd_gc/rd_count are pure register outputs.
// - Read and accept in the same cycle are both legal. The read returns the pre-add value.
// - clear in IDLE: acc, rd_count and rd_gc are zeroed next cycle. No accept occurs in that cycle.
// - clear in ADD: clear_pend is set. The in-flight sum is discarded on completion, acc and count are zeroed, clear_pend drops, and the FSM returns to IDLE.
// - Repeated clear while clear_pend is set: no additional effect.
// - busy = (state==ADD).
// - fadd result format (NaN/inf/denormal handling) is whatever fadd produces. acc_unit never alters it.
// - reset mid-ADD: the in-flight sum is dropped and the full reset state is restored next cycle.
// - Arithmetic: lat_cnt is $clog2(FADD_LAT+1) bits. FADD_LAT=1 gives a single ADD cycle.
// STRUCTURE
// - Shared package / common.vh: the GC_WIDTH constant and req_if interface already live there.
// - Shared package: add the acc_state_t enum {IDLE, ADD}.
// - Sub-module: the team fadd core, instantiated once. Its pipeline depth must equal FADD_LAT.
// - fadd must be fully pipelined or hold its output. acc_unit samples the result only at lat_cnt==0.
// - Everything else (FSM, counters, clear_pend, output regs) is local to acc_unit.
// TESTING
// - Reset, then push 1.0 (3f800000), then 2.0 (40000000) -> rd_data=40400000, rd_count=2, busy high FADD_LAT cycles per add.
// - Hold acc_req.valid continuously with 1.0 x4 -> accepts spaced exactly FADD_LAT+1 cycles, final rd_data=40800000.
// - Accept 2.0 with gc_stamp=5 while rd_req.valid=1 on the same cycle -> read returns prior value 0, rd_gc=5 after the accept.
// - clear in IDLE with acc_req.valid=1 -> no accept that cycle. Next cycle rd_data=0 and rd_count=0. Accept on the following cycle.
// - clear during ADD of 3.0 onto 1.0 -> completion leaves rd_data=0 and rd_count=0, never 40800000.
// - reset asserted mid-ADD -> next cycle all outputs are at reset values, and acc_req.ready stays 0 while reset is high.

Source files
------------

// File: rtl/acc_unit_pkg.sv
// Shared definitions for the accumulator unit.
//   GC_WIDTH    - width of the gc stamp carried with each operand
//   acc_state_t - controller state: IDLE (can accept/read) or ADD (sum in flight)
package acc_unit_pkg;

    localparam int GC_WIDTH = 8;

    typedef enum logic {
        IDLE,
        ADD
    } acc_state_t;

endpackage

// File: rtl/acc_unit_if.sv
// req_if: generic valid/ready handshake.
//   master - drives valid, observes ready
//   slave  - observes valid, drives ready
// A transfer happens on every clock edge where valid && ready.
interface req_if;
    logic valid;
    logic ready;

    modport master (output valid, input ready);
    modport slave  (input valid, output ready);
endinterface

// File: rtl/acc_unit_fadd.sv
// acc_unit_fadd: FP32 adder with a fixed pipeline depth of LAT cycles.
//   clk - clock
//   a   - FP32 operand, sampled every cycle
//   b   - FP32 operand, sampled every cycle
//   sum - a+b, valid LAT cycles after the operands were presented
// The pipeline is fully pipelined: a new operand pair may enter every cycle.
// Denormal inputs are flushed to zero and tiny results flush to signed zero.
// Inf/NaN inputs pass through unchanged. Rounding is round-to-nearest-even.
module acc_unit_fadd #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    function automatic logic [31:0] fp_add(input logic [31:0] fa, input logic [31:0] fb);
        logic [31:0] x, y;
        logic [26:0] mx, my, mask;
        logic [27:0] s;
        logic [24:0] m;
        logic        sgn, rnd;
        int          e, d;

        if (fa[30:23] == 8'hff) return fa;
        if (fb[30:23] == 8'hff) return fb;
        if (fa[30:23] == 8'h00) return (fb[30:23] == 8'h00) ? 32'h0 : fb;
        if (fb[30:23] == 8'h00) return fa;

        // Order by magnitude so the aligned subtraction never goes negative.
        if (fa[30:0] >= fb[30:0]) begin
            x = fa;
            y = fb;
        end else begin
            x = fb;
            y = fa;
        end

        sgn = x[31];
        e   = int'(x[30:23]);
        d   = int'(x[30:23]) - int'(y[30:23]);
        mx  = {1'b1, x[22:0], 3'b000};
        my  = {1'b1, y[22:0], 3'b000};

        // Align the smaller operand; bits shifted out collapse into the sticky bit.
        if (d > 26) begin
            my = 27'd1;
        end else if (d > 0) begin
            mask = (27'd1 << d[4:0]) - 27'd1;
            my   = (my >> d[4:0]) | {26'd0, |(my & mask)};
        end

        if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
        else                s = {1'b0, mx} - {1'b0, my};

        if (s == 28'd0) return 32'h0;

        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!s[26]) begin
                s = s << 1;
                e = e - 1;
            end
        end
        if (e <= 0) return {sgn, 31'd0};

        rnd = s[2] & (s[1] | s[0] | s[3]);
        m   = {1'b0, s[26:3]} + {24'd0, rnd};
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {sgn, 8'hff, 23'd0};
        return {sgn, e[7:0], m[22:0]};
    endfunction

    logic [31:0] pipe [LAT];

    // NOTE: these are pure datapath registers with no reset; the controller
    // only samples the last stage when it knows a valid sum is there.
    always_ff @(posedge clk) begin
        pipe[0] <= fp_add(a, b);
        for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign sum = pipe[LAT-1];

endmodule

// File: rtl/acc_unit.sv
// acc_unit: serial FP32 accumulator behind a valid/ready dispatch port.
//   clk       - clock
//   reset     - synchronous, active-high reset
//   acc_req   - operand handshake (slave): valid in, ready out
//   acc_data  - FP32 operand, qualified by acc_req.valid
//   gc_stamp  - gc stamp of the operand, qualified by acc_req.valid
//   clear     - pulse: zero accumulator, counter and gc stamp
//   rd_req    - read handshake (slave): valid in, ready out
//   rd_data   - accumulator value
//   rd_gc     - gc stamp of the last accumulated operand
//   rd_count  - operands accumulated since reset/clear, saturating
//   busy      - an add is in flight
// One add is in flight at a time because each sum feeds the next add.
module acc_unit
    import acc_unit_pkg::*;
#(
    parameter int FADD_LAT  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    req_if.slave                 acc_req,
    input  logic [31:0]          acc_data,
    input  logic [GC_WIDTH-1:0]  gc_stamp,
    input  logic                 clear,
    req_if.slave                 rd_req,
    output logic [31:0]          rd_data,
    output logic [GC_WIDTH-1:0]  rd_gc,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic                 busy
);

    localparam int               LAT_W    = $clog2(FADD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(FADD_LAT - 1);

    acc_state_t       state, state_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
    logic [31:0]      acc, fadd_sum;
    logic             accept, add_done, clear_pend;

    // Read data are plain registers, so a read needs no qualification beyond
    // ready; a read in the same cycle as an accept sees the pre-add value.
    assign acc_req.ready = (state == IDLE) && !clear && !reset;
    assign rd_req.ready  = (state == IDLE) && !reset;
    assign accept        = acc_req.valid && acc_req.ready;
    assign busy          = (state == ADD);
    assign rd_data       = acc;

    // The first fadd stage captures (acc, acc_data) on the accept edge; the
    // sum reaches the output exactly when lat_cnt reaches zero.
    acc_unit_fadd #(.LAT(FADD_LAT)) u_fadd (
        .clk (clk),
        .a   (acc),
        .b   (acc_data),
        .sum (fadd_sum)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // updates from the values present before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    // NOTE: all outputs of this block get a default first, so no path
    // leaves them unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        add_done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = ADD;
                    lat_cnt_nxt = LAT_LOAD;
                end
            end
            ADD: begin
                if (lat_cnt == '0) begin
                    state_nxt = IDLE;
                    add_done  = 1'b1;
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            rd_gc      <= '0;
            rd_count   <= '0;
            clear_pend <= 1'b0;
        end else begin
            if ((state == IDLE) && clear) begin
                acc      <= '0;
                rd_gc    <= '0;
                rd_count <= '0;
            end else if (accept) begin
                rd_gc <= gc_stamp;
                if (rd_count != '1) rd_count <= rd_count + CNT_WIDTH'(1);
            end

            // A clear during an add is remembered and applied when the add
            // retires, so the in-flight sum can never overwrite the zeroing.
            if (busy && clear) clear_pend <= 1'b1;

            if (add_done) begin
                clear_pend <= 1'b0;
                if (clear_pend || clear) begin
                    acc      <= '0;
                    rd_gc    <= '0;
                    rd_count <= '0;
                end else begin
                    acc <= fadd_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: self-checking bench for acc_unit.
// Operands are small non-negative integers encoded as FP32, so every running
// sum is exact and the reference model can keep it as a plain integer.
// Reads push their expected value into a queue; a monitor pops and compares
// on every read handshake.
module tb_acc_unit;
    import acc_unit_pkg::*;

    localparam int LAT     = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0]         data;
        logic [CNT_W-1:0]    cnt;
        logic [GC_WIDTH-1:0] gc;
    } rd_exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         acc_data;
    logic [GC_WIDTH-1:0] gc_stamp;
    logic                clear;
    logic [31:0]         rd_data;
    logic [GC_WIDTH-1:0] rd_gc;
    logic [CNT_W-1:0]    rd_count;
    logic                busy;

    req_if acc_req_if ();
    req_if rd_req_if ();

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int unsigned         exp_sum;
    int                  exp_cnt;
    logic [GC_WIDTH-1:0] exp_gc;
    rd_exp_t             exp_q [$];

    acc_unit #(.FADD_LAT(LAT), .CNT_WIDTH(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .acc_req  (acc_req_if),
        .acc_data (acc_data),
        .gc_stamp (gc_stamp),
        .clear    (clear),
        .rd_req   (rd_req_if),
        .rd_data  (rd_data),
        .rd_gc    (rd_gc),
        .rd_count (rd_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Integer -> FP32 bits; exact for values below 2^24.
    function automatic logic [31:0] int_to_fp(input int unsigned v);
        int          p;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 24; i++) if (v[i]) p = i;
        m = (v << (23 - p)) & 32'h007f_ffff;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic rd_exp_t cur_exp();
        return '{data: int_to_fp(exp_sum), cnt: CNT_W'(exp_cnt), gc: exp_gc};
    endfunction

    task automatic model_accept(input int unsigned v, input logic [GC_WIDTH-1:0] g);
        exp_sum = exp_sum + v;
        if (exp_cnt < CNT_MAX) exp_cnt++;
        exp_gc = g;
    endtask

    task automatic model_clear();
        exp_sum = 0;
        exp_cnt = 0;
        exp_gc  = '0;
    endtask

    // Monitor: compare every read handshake against the queued expectation.
    always @(negedge clk) begin : monitor
        rd_exp_t e;
        if (rd_req_if.valid && rd_req_if.ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: read with no expectation, rd_data=%h", rd_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_count", 32'(rd_count), 32'(e.cnt));
                check("rd_gc", 32'(rd_gc), 32'(e.gc));
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_idle");
        @(posedge clk); #1;
    endtask

    task automatic do_read();
        bit ok = 1'b0;
        exp_q.push_back(cur_exp());
        rd_req_if.valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_req_if.ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("read_ready");
        @(posedge clk); #1;
        rd_req_if.valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
    endtask

    // Single accept, then check busy duration and the sum's arrival cycle.
    task automatic do_acc(input int unsigned v, input logic [GC_WIDTH-1:0] g);
        bit ok   = 1'b0;
        int bcnt = 0;
        acc_req_if.valid = 1'b1;
        acc_data         = int_to_fp(v);
        gc_stamp         = g;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_req_if.ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) model_accept(v, g);
        else    timeout("acc_ready");
        @(posedge clk); #1;
        acc_req_if.valid = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (!busy) break;
            bcnt++;
        end
        check("busy_cycles", 32'(bcnt), 32'(LAT));
        check("acc_result", rd_data, int_to_fp(exp_sum));
        check("acc_count", 32'(rd_count), 32'(exp_cnt));
        @(posedge clk); #1;
    endtask

    // Hold valid high for n accepts and check their spacing.
    task automatic hold_acc(input int n, input int unsigned v, input logic [GC_WIDTH-1:0] g);
        int got  = 0;
        int last = 0;
        bit ok   = 1'b0;
        acc_req_if.valid = 1'b1;
        acc_data         = int_to_fp(v);
        gc_stamp         = g;
        for (int i = 0; i < n * (LAT + 1) + 20; i++) begin
            @(negedge clk);
            if (acc_req_if.ready) begin
                if (got > 0) check("accept_spacing", 32'(cyc - last), 32'(LAT + 1));
                last = cyc;
                got++;
                model_accept(v, g);
            end
            @(posedge clk); #1;
            if (got == n) begin
                ok = 1'b1;
                break;
            end
        end
        acc_req_if.valid = 1'b0;
        if (!ok) timeout("hold_acc");
        wait_idle();
    endtask

    // Accept and read in the same cycle; the read must see the pre-add value.
    task automatic do_acc_read(input int unsigned v, input logic [GC_WIDTH-1:0] g);
        exp_q.push_back(cur_exp());
        rd_req_if.valid  = 1'b1;
        acc_req_if.valid = 1'b1;
        acc_data         = int_to_fp(v);
        gc_stamp         = g;
        @(negedge clk);
        check("concur_acc_ready", 32'(acc_req_if.ready), 32'd1);
        check("concur_rd_ready", 32'(rd_req_if.ready), 32'd1);
        if (acc_req_if.ready) model_accept(v, g);
        @(posedge clk); #1;
        rd_req_if.valid  = 1'b0;
        acc_req_if.valid = 1'b0;
        wait_idle();
        check("concur_gc", 32'(rd_gc), 32'(exp_gc));
    endtask

    initial begin
        reset            = 1'b1;
        clear            = 1'b0;
        acc_req_if.valid = 1'b1;
        rd_req_if.valid  = 1'b0;
        acc_data         = 32'h3f80_0000;
        gc_stamp         = '0;
        model_clear();

        // Reset values, with acc_req.valid held high throughout.
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rst_acc_ready", 32'(acc_req_if.ready), 32'd0);
        check("rst_rd_ready", 32'(rd_req_if.ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_rd_gc", 32'(rd_gc), 32'd0);
        @(posedge clk); #1;
        reset            = 1'b0;
        acc_req_if.valid = 1'b0;
        @(negedge clk);
        check("post_rst_acc_ready", 32'(acc_req_if.ready), 32'd1);
        check("post_rst_rd_ready", 32'(rd_req_if.ready), 32'd1);
        @(posedge clk); #1;

        // 1.0 + 2.0 = 3.0
        do_acc(1, 8'd1);
        do_acc(2, 8'd2);
        check("sum_1_2", rd_data, 32'h4040_0000);
        do_read();

        // Back-to-back accepts with valid held high: 4 x 1.0 = 4.0
        do_clear();
        hold_acc(4, 1, 8'd3);
        check("sum_4x1", rd_data, 32'h4080_0000);
        do_read();

        // Accept 2.0 (gc 5) together with a read of the cleared accumulator.
        do_clear();
        do_acc_read(2, 8'd5);
        check("concur_gc5", 32'(rd_gc), 32'd5);
        do_read();

        // Clear in IDLE blocks the accept for that cycle only.
        clear            = 1'b1;
        acc_req_if.valid = 1'b1;
        acc_data         = int_to_fp(3);
        gc_stamp         = 8'd9;
        @(negedge clk);
        check("clr_blocks_ready", 32'(acc_req_if.ready), 32'd0);
        model_clear();
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_rd_data", rd_data, 32'h0);
        check("clr_rd_count", 32'(rd_count), 32'd0);
        check("clr_rd_gc", 32'(rd_gc), 32'd0);
        check("clr_then_ready", 32'(acc_req_if.ready), 32'd1);
        if (acc_req_if.ready) model_accept(3, 8'd9);
        @(posedge clk); #1;
        acc_req_if.valid = 1'b0;
        wait_idle();
        do_read();

        // Clear while 3.0 is being added onto 1.0: result must be zero.
        do_clear();
        do_acc(1, 8'd1);
        acc_req_if.valid = 1'b1;
        acc_data         = int_to_fp(3);
        gc_stamp         = 8'd2;
        @(negedge clk);
        check("clr_add_accept", 32'(acc_req_if.ready), 32'd1);
        @(posedge clk); #1;
        acc_req_if.valid = 1'b0;
        clear            = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        wait_idle();
        @(negedge clk);
        check("clr_add_rd_data", rd_data, 32'h0);
        check("clr_add_rd_count", 32'(rd_count), 32'd0);
        model_clear();
        @(posedge clk); #1;
        do_read();

        // Reset in the middle of an add.
        do_acc(6, 8'd4);
        acc_req_if.valid = 1'b1;
        acc_data         = int_to_fp(5);
        gc_stamp         = 8'd7;
        @(negedge clk);
        check("mid_rst_accept", 32'(acc_req_if.ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_acc_ready", 32'(acc_req_if.ready), 32'd0);
        check("mid_rst_rd_ready", 32'(rd_req_if.ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd_data", rd_data, 32'h0);
        check("mid_rst_rd_count", 32'(rd_count), 32'd0);
        check("mid_rst_rd_gc", 32'(rd_gc), 32'd0);
        check("mid_rst_hold_ready", 32'(acc_req_if.ready), 32'd0);
        @(posedge clk); #1;
        reset            = 1'b0;
        acc_req_if.valid = 1'b0;
        model_clear();
        @(negedge clk);
        check("mid_rst_release_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        do_read();

        // Randomized mix of accepts, reads, clears and concurrent accept+read.
        for (int it = 0; it < 40; it++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r <= 5)      do_acc($urandom_range(0, 15), GC_WIDTH'($urandom));
            else if (r <= 7) do_read();
            else if (r == 8) do_clear();
            else             do_acc_read($urandom_range(0, 15), GC_WIDTH'($urandom));
        end
        do_read();

        // Count saturates at all-ones while the sum keeps growing.
        do_clear();
        hold_acc(CNT_MAX + 2, 1, 8'd11);
        check("sat_count", 32'(rd_count), 32'(CNT_MAX));
        do_read();

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rd_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
